cache_refill_ctrl: RTL
======================

// Module: cache_refill_ctrl
// PURPOSE
// - Miss handler sitting upstream of the direct-mapped data cache (1024 lines x 4 words, 3-bit tag).
// - Takes CPU load/store requests, serves load hits straight from the cache and stalls the CPU on load misses.
// - On a miss, fetches the 4-word line from data memory one word at a time and writes it into the cache as one 128-bit line.
// - Stores are write-through and no-write-allocate; a store that hits refetches its line after the memory write completes.
// PARAMETERS
// - ADDR_W  15  CPU word address: tag[14:12], index[11:2], word[1:0]
// - WORD_W  32  data word width
// - LINE_WORDS  4  words per line; fixed by the cache; must be 4
// PORTS
// - clk  in  1  single clock, rising edge
// - rst  in  1  asynchronous, active-high reset
// - cpu_rd  in  1  load request; held with addr stable while cpu_stall=1
// - cpu_wr  in  1  store request; wins if asserted together with cpu_rd
// - cpu_addr  in  15  word address
// - cpu_wdata  in  32  store data
// - cpu_rdata  out  32  load data; valid when cpu_rd=1 and cpu_stall=0
// - cpu_stall  out  1  CPU must hold its request
// - cache_addr  out  15  address to the cache (cpu_addr in IDLE, latched address otherwise)
// - cache_rd_en  out  1  cache read enable
// - cache_wr_en  out  1  one-cycle line write
// - cache_line  out  128  refill line; word k at [32k+31:32k]
// - cache_hit  in  1  combinational hit for cache_addr
// - cache_rdata  in  32  combinational word for cache_addr
// - mem_req  out  1  memory request; held until mem_ack
// - mem_we  out  1  1 = write, 0 = read
// - mem_addr  out  15  word address, stable while mem_req=1
// - mem_wdata  out  32  write data
// - mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle on reads
// - mem_rdata  in  32  read data
// - hit_cnt, miss_cnt  out  16 each  statistics (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: all outputs 0, FSM in IDLE, line buffer and beat counter cleared.
// - Reset mid-operation aborts immediately: no cache write, mem_req drops, cpu_stall drops.
// - IDLE:
//   - cpu_wr: latch addr and wdata; cpu_stall=1; go to WR_MEM.
//   - else cpu_rd && cache_hit: cpu_rdata=cache_rdata and cpu_stall=0, same cycle (zero latency).
//   - else cpu_rd && !cache_hit: cpu_stall=1 combinationally; latch addr; beat=0; go to FETCH.
// - FETCH:
//   - mem_req=1, mem_we=0, mem_addr={tag,index,beat[1:0]}.
//   - On mem_ack: buffer[beat]<=mem_rdata and beat++.
//   - Back-to-back beats allowed: the next address is presented the cycle after ack.
//   - After beat 3 is acked, go to FILL.
// - FILL:
//   - cache_wr_en=1 for exactly one cycle, cache_addr=latched, cache_line=buffer.
//   - Go to RESP if the refill came from a load, else to IDLE with cpu_stall=0 on the next cycle.
// - RESP: cpu_rdata=buffer[latched word], cpu_stall=0 for one cycle; go to IDLE.
// - WR_MEM:
//   - mem_req=1, mem_we=1, mem_addr=latched, mem_wdata=latched.
//   - On mem_ack: go to FETCH if the line hit at issue (hit latched in IDLE), else to IDLE.
// - Miss penalty with 1-cycle memory ack: 4 fetch + FILL + RESP = 6 cycles of stall.
// - mem_ack outside FETCH/WR_MEM is ignored. The beat counter wraps 3->0 only on the FETCH->FILL transition.
// CONFIGURATION
// - CTRL_STATS_EN defined: hit_cnt++ on every IDLE load hit, miss_cnt++ on every load miss entry.
//   - Both counters are 16-bit saturating at 0xFFFF and cleared by rst.
// - CTRL_STATS_EN undefined: hit_cnt and miss_cnt tied to 0 and no counter flops; the port list is unchanged.
// STRUCTURE
// - cache_pkg: ADDR_W, WORD_W, LINE_WORDS, TAG/INDEX/WORD field-slice constants, state enum {IDLE,FETCH,FILL,RESP,WR_MEM}.
// - Sub-module refill_line_buf: 4x32 buffer, 2-bit beat counter, beat-done flag, 128-bit line output.
// TESTING
// - Load hit: preload cache line, cpu_rd addr 0x1234 -> cpu_stall=0 and cpu_rdata=line word 0 in the same cycle; hit_cnt=1.
// - Load miss: addr 0x5006, memory returns 0xA0..0xA3 with 1-cycle ack -> mem_addr 0x5004..0x5007.
//   - Then cache_wr_en for one cycle with cache_line={A3,A2,A1,A0}.
//   - Then cpu_rdata=0xA2; stall lasts 6 cycles.
// - Slow memory: ack 3 cycles after each req -> mem_addr held stable; stall lasts 4*3+2 cycles; line correct.
// - Store miss: cpu_wr addr 0x0010 with data 0xDEADBEEF -> one mem write, no cache_wr_en, return to IDLE.
// - Store hit: one mem write, then a 4-beat refetch and FILL; a subsequent load returns 0xDEADBEEF as a hit.
// - Reset during FETCH beat 2 -> all outputs 0, no cache_wr_en; the next load to the same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared geometry constants and FSM state type for the refill
//               controller in front of the 1024 x 4-word direct-mapped cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;
    localparam int ADDR_W     = 15;
    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = WORD_W * LINE_WORDS;
    localparam int BEAT_W     = 2;

    // CPU word address = tag[14:12] | index[11:2] | word[1:0]
    localparam int TAG_MSB   = 14;
    localparam int TAG_LSB   = 12;
    localparam int INDEX_MSB = 11;
    localparam int INDEX_LSB = 2;
    localparam int WORD_MSB  = 1;
    localparam int WORD_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        FILL   = 3'd2,
        RESP   = 3'd3,
        WR_MEM = 3'd4
    } state_t;
endpackage
`default_nettype wire

// File: rtl/refill_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : refill_line_buf
// Description : Four-word line buffer filled one memory beat at a time, with
//               a wrapping beat counter and a last-beat flag.
// Revision    : 1.0 - initial release
// ============================================================================
module refill_line_buf
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wdata,
    output logic [BEAT_W-1:0] beat,
    output logic              last_beat,
    output logic [LINE_W-1:0] line
);
    logic [WORD_W-1:0] word_q [LINE_WORDS];
    logic [WORD_W-1:0] word_d [LINE_WORDS];
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;

    always_comb begin
        word_d = word_q;
        beat_d = beat_q;
        if (clr) begin
            beat_d = '0;
        end else if (wr_en) begin
            word_d[beat_q] = wdata;
            beat_d         = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '{default: '0};
            beat_q <= '0;
        end else begin
            word_q <= word_d;
            beat_q <= beat_d;
        end
    end

    assign beat      = beat_q;
    assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_line
        assign line[k*WORD_W +: WORD_W] = word_q[k];
    end
endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Load-miss refill and write-through store handler for the
//               direct-mapped data cache. Define CTRL_STATS_EN for counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_rd_en,
    output logic              cache_wr_en,
    output logic [LINE_W-1:0] cache_line,
    input  logic              cache_hit,
    input  logic [WORD_W-1:0] cache_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              hit_q, hit_d;    // store hit its line when issued
    logic              load_q, load_d;  // current refill answers a load
    logic              buf_clr;
    logic              buf_wr;
    logic              last_beat;
    logic [BEAT_W-1:0] beat;
    logic [LINE_W-1:0] line;

    refill_line_buf u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (buf_clr),
        .wr_en     (buf_wr),
        .wdata     (mem_rdata),
        .beat      (beat),
        .last_beat (last_beat),
        .line      (line)
    );

    assign cache_line = line;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hit_d       = hit_q;
        load_d      = load_q;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        cpu_rdata   = '0;
        cpu_stall   = 1'b0;
        cache_addr  = addr_q;
        cache_rd_en = 1'b0;
        cache_wr_en = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                cache_addr  = cpu_addr;
                cache_rd_en = cpu_rd | cpu_wr;
                if (cpu_wr) begin
                    cpu_stall = 1'b1;
                    addr_d    = cpu_addr;
                    wdata_d   = cpu_wdata;
                    hit_d     = cache_hit;
                    load_d    = 1'b0;
                    state_d   = WR_MEM;
                end else if (cpu_rd) begin
                    if (cache_hit) begin
                        cpu_rdata = cache_rdata;
                    end else begin
                        cpu_stall = 1'b1;
                        addr_d    = cpu_addr;
                        load_d    = 1'b1;
                        buf_clr   = 1'b1;
                        state_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {addr_q[ADDR_W-1:INDEX_LSB], beat};
                if (mem_ack) begin
                    buf_wr = 1'b1;
                    if (last_beat) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                cpu_stall   = 1'b1;
                cache_wr_en = 1'b1;
                state_d     = load_q ? RESP : IDLE;
            end
            RESP: begin
                cpu_rdata = line[int'(addr_q[WORD_MSB:WORD_LSB])*WORD_W +: WORD_W];
                state_d   = IDLE;
            end
            WR_MEM: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    // write-through keeps a resident line coherent by refetching it
                    if (hit_q) begin
                        buf_clr = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hit_q   <= hit_d;
            load_q  <= load_d;
        end
    end

`ifdef CTRL_STATS_EN
    logic        ld_hit, ld_miss;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    assign ld_hit  = (state_q == IDLE) && !cpu_wr && cpu_rd && cache_hit;
    assign ld_miss = (state_q == IDLE) && !cpu_wr && cpu_rd && !cache_hit;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (ld_hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (ld_miss && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule
`default_nettype wire
